// File: rtl/icb_slave_arbiter.sv
// Grants exclusive ICB slave access to one requesting master, held until that master signals done.
// Request-to-grant latency 1 cycle; one idle cycle after every release; optional hang timeout.
module icb_slave_arbiter #(
   parameter int NUM_MASTERS    = 5,
   parameter int PRIORITY_MODE  = 0,
   parameter int TIMEOUT_CYCLES = 0,
   localparam int IDW           = $clog2(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [NUM_MASTERS-1:0] done,
   output logic [NUM_MASTERS-1:0] granted,
   output logic                   grant_valid,
   output logic [IDW-1:0]         grant_id,
   output logic                   timeout_err,
   output logic [IDW-1:0]         timeout_id
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state;
   logic [IDW-1:0] rr_ptr;
   logic [CW-1:0]  cnt;
   logic           win_found;
   logic [IDW-1:0] win_idx;
   logic [IDW-1:0] next_ptr;
   int             j;

   // Scan from rr_ptr (round-robin) or from index 0 (fixed priority), wrapping at the top.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      j         = 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         j = (PRIORITY_MODE != 0) ? i : int'(rr_ptr) + i;
         if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
         if (!win_found && req[j]) begin
            win_found = 1'b1;
            win_idx   = IDW'(j);
         end
      end
   end

   always_comb begin
      next_ptr = '0;
      if (int'(grant_id) != NUM_MASTERS - 1) next_ptr = grant_id + IDW'(1);
   end

   assign grant_valid = |granted;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         cnt         <= '0;
         granted     <= '0;
         grant_id    <= '0;
         timeout_err <= 1'b0;
         timeout_id  <= '0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  granted  <= NUM_MASTERS'(1) << win_idx;
                  grant_id <= win_idx;
                  cnt      <= '0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               // A done arriving on the timeout cycle wins: normal release, no error.
               if (done[grant_id]) begin
                  granted <= '0;
                  rr_ptr  <= next_ptr;
                  state   <= IDLE;
               end else if (TIMEOUT_CYCLES > 0 && int'(cnt) == TIMEOUT_CYCLES - 1) begin
                  granted     <= '0;
                  rr_ptr      <= next_ptr;
                  state       <= IDLE;
                  timeout_err <= 1'b1;
                  timeout_id  <= grant_id;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/icb_slave_arbiter.md
Name: icb_slave_arbiter

Overview:
- Arbiter end of the ICB slave req/granted/done handshake.
- Accepts up to NUM_MASTERS requesting loaders/writers (IA, weight, bias, requant, OA).
- Grants exclusive ICB access to one master at a time and holds the grant until that master pulses done.
- Drives a select index for the downstream ICB mux.
- Provides round-robin or fixed priority, plus an optional hang-protection timeout.

Parameters:
- NUM_MASTERS, 5, number of icb_slave_if arbiter-side ports (>=2).
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed (lowest index wins).
- TIMEOUT_CYCLES, 0, maximum grant length in cycles; 0 disables the timeout.
- IDW, $clog2(NUM_MASTERS), width of index outputs (derived, not overridden).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_MASTERS  per-master request (icb_slave_if.req).
- done  in  NUM_MASTERS  per-master one-cycle transfer-complete pulse (icb_slave_if.done).
- granted  out  NUM_MASTERS  one-hot or zero grant (icb_slave_if.granted), registered.
- grant_valid  out  1  high while any grant is active (OR of granted).
- grant_id  out  IDW  index of the granted master; holds last value when grant_valid=0.
- timeout_err  out  1  one-cycle pulse when a grant is force-released.
- timeout_id  out  IDW  index of the master that timed out; valid with timeout_err, then held.

Behaviour:
- Reset (rst=1 at posedge):
  - granted=0, grant_valid=0, grant_id=0, timeout_err=0, timeout_id=0.
  - State IDLE, rr_ptr=0, timeout counter=0.
  - Reset mid-grant drops granted on that same edge. No done is expected afterwards.
- State IDLE:
  - If req!=0 at cycle t, select the winner combinationally.
  - Register granted[w]=1 and grant_id=w; they are visible in cycle t+1. Go to BUSY.
  - Request-to-grant latency is 1 cycle.
  - If req=0, stay in IDLE.
- Winner selection:
  - Round-robin: first set req bit scanning rr_ptr, rr_ptr+1, ..., wrapping NUM_MASTERS-1 to 0.
  - Fixed: lowest set index. rr_ptr is ignored.
- State BUSY:
  - Grant is held regardless of req; a master dropping req without done still keeps the grant.
  - done[grant_id]=1 at cycle t: granted=0 at t+1, state IDLE, rr_ptr=(grant_id+1) mod NUM_MASTERS (wrap at NUM_MASTERS-1 to 0).
  - This gives a mandatory one-cycle gap: the earliest next grant is at t+2.
  - done from non-granted masters is ignored in BUSY; all done is ignored in IDLE.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on grant and increments every BUSY cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 with no done: release exactly as for a done (granted=0 next cycle, rr_ptr advanced).
  - timeout_err pulses for that one cycle with timeout_id=grant_id.
  - done and timeout in the same cycle: treat as done; no error.
- Invariants:
  - granted is never multi-hot.
  - grant_valid == |granted.
  - No grant is issued in the cycle immediately after a release.
- New req arriving during BUSY waits; it is not queued separately, only sampled in IDLE.

Test Plan:
- Single master: req[2]=1 at cycle 1 -> granted=5'b00100, grant_id=2 at cycle 2; done[2] pulse at cycle 6 -> granted=0 at cycle 7.
- Round-robin fairness: req=5'b11111 held, each master pulses done 3 cycles after its grant -> grant order 0,1,2,3,4,0; one idle cycle between grants.
- Fixed priority (PRIORITY_MODE=1): req=5'b10110 held, done after each grant -> master 1 is always granted; masters 2 and 4 are starved.
- Spurious done: while master 3 holds the grant, pulse done[0] and done[1] and drop req[3] -> grant stays on 3 until done[3].
- Timeout (TIMEOUT_CYCLES=8): master 4 is granted and never pulses done -> granted=0 after 8 grant cycles; timeout_err=1 for 1 cycle with timeout_id=4; next requester granted 1 cycle later. Also pulse done on exactly the 8th cycle -> no timeout_err.
- Reset mid-grant: assert rst while master 1 is granted -> all outputs 0 at the next edge; after release, req=5'b00011 -> master 0 granted (rr_ptr=0).
